// File: rtl/lcd_hd44780_bus_ctrl.sv
// HD44780-style LCD bus master: one request per handshake, programmable bus timing,
// optional busy-flag polling after writes with a bounded poll count.
module lcd_hd44780_bus_ctrl #(
  parameter int unsigned G_TAS_CYC  = 4,
  parameter int unsigned G_PWEH_CYC = 24,
  parameter int unsigned G_TAH_CYC  = 2,
  parameter int unsigned G_TCYC_CYC = 50,
  parameter int unsigned G_POLL_MAX = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_rs,
  input  logic        i_req_rw,
  input  logic [7:0]  i_req_data,
  input  logic        i_poll_en,
  output logic        o_done,
  output logic        o_timeout,
  output logic [7:0]  o_rdata,
  output logic [15:0] o_poll_cnt,
  output logic        o_rs,
  output logic        o_rw,
  output logic        o_en,
  inout  logic [7:0]  io_data
);

  localparam logic [15:0] TAS_LAST  = 16'((G_TAS_CYC  == 0 ? 1 : G_TAS_CYC)  - 1);
  localparam logic [15:0] PWEH_LAST = 16'((G_PWEH_CYC == 0 ? 1 : G_PWEH_CYC) - 1);
  localparam logic [15:0] TAH_LAST  = 16'((G_TAH_CYC  == 0 ? 1 : G_TAH_CYC)  - 1);
  localparam logic [15:0] TCYC      = 16'(G_TCYC_CYC == 0 ? 1 : G_TCYC_CYC);
  localparam logic [15:0] POLL_MAX  = 16'(G_POLL_MAX == 0 ? 1 : G_POLL_MAX);

  typedef enum logic [2:0] {IDLE, SETUP, ENH, HOLD, GAP, DONE} state_t;

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [15:0] cyc, cyc_d;
  logic        rs_q, rs_d, rw_q, rw_d, en_q, en_d, drive_q, drive_d;
  logic [7:0]  data_q, data_d, rdata_q, rdata_d;
  logic        req_rw_q, req_rw_d, poll_req_q, poll_req_d;
  logic        polling_q, polling_d, bf_q, bf_d;
  logic [15:0] pcnt_q, pcnt_d, pcnt_out_q, pcnt_out_d;
  logic        timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cyc        <= '0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      en_q       <= 1'b0;
      drive_q    <= 1'b0;
      data_q     <= '0;
      rdata_q    <= '0;
      req_rw_q   <= 1'b0;
      poll_req_q <= 1'b0;
      polling_q  <= 1'b0;
      bf_q       <= 1'b0;
      pcnt_q     <= '0;
      pcnt_out_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cyc        <= cyc_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      en_q       <= en_d;
      drive_q    <= drive_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      req_rw_q   <= req_rw_d;
      poll_req_q <= poll_req_d;
      polling_q  <= polling_d;
      bf_q       <= bf_d;
      pcnt_q     <= pcnt_d;
      pcnt_out_q <= pcnt_out_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt + 16'd1;
    cyc_d      = (cyc == '1) ? cyc : cyc + 16'd1;
    rs_d       = rs_q;
    rw_d       = rw_q;
    en_d       = en_q;
    drive_d    = drive_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    req_rw_d   = req_rw_q;
    poll_req_d = poll_req_q;
    polling_d  = polling_q;
    bf_d       = bf_q;
    pcnt_d     = pcnt_q;
    pcnt_out_d = pcnt_out_q;
    timeout_d  = timeout_q;

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (i_req_valid) begin
          rs_d       = i_req_rs;
          rw_d       = i_req_rw;
          data_d     = i_req_data;
          drive_d    = !i_req_rw;
          req_rw_d   = i_req_rw;
          poll_req_d = i_poll_en && !i_req_rw;
          polling_d  = 1'b0;
          bf_d       = 1'b0;
          pcnt_d     = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (cnt == TAS_LAST) begin
          en_d    = 1'b1;
          cnt_d   = '0;
          cyc_d   = '0;
          state_d = ENH;
        end
      end
      ENH: begin
        if (cnt == PWEH_LAST) begin
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = HOLD;
          if (polling_q) begin
            bf_d   = io_data[7];
            pcnt_d = pcnt_q + 16'd1;
          end else if (req_rw_q) begin
            rdata_d = io_data;
          end
        end
      end
      HOLD: begin
        if (cnt == TAH_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = '0;
        if (cyc >= TCYC) begin
          if ((!polling_q && poll_req_q) || (polling_q && bf_q && pcnt_q < POLL_MAX)) begin
            rs_d      = 1'b0;
            rw_d      = 1'b1;
            drive_d   = 1'b0;
            polling_d = 1'b1;
            state_d   = SETUP;
          end else begin
            rs_d       = 1'b0;
            rw_d       = 1'b0;
            drive_d    = 1'b0;
            pcnt_out_d = pcnt_q;
            timeout_d  = polling_q && bf_q && (pcnt_q == POLL_MAX);
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Separate drive flag keeps the bus released in IDLE even though rw idles at 0.
  assign io_data     = (drive_q && !rw_q) ? data_q : 'z;
  assign o_req_ready = (state == IDLE);
  assign o_done      = (state == DONE);
  assign o_timeout   = timeout_q;
  assign o_rdata     = rdata_q;
  assign o_poll_cnt  = pcnt_out_q;
  assign o_rs        = rs_q;
  assign o_rw        = rw_q;
  assign o_en        = en_q;

endmodule

// File: doc/lcd_hd44780_bus_ctrl.md
Name: lcd_hd44780_bus_ctrl

Overview:
- Upstream driver for the character-LCD physical bus (rs, rw, en, 8-bit data). Feeds the team's LCD emulator/checker in simulation and the real module on hardware.
- Accepts one command/data byte per request handshake and generates the bus cycle with programmable tAS/PWEH/tAH/tcycE timing.
- After a write it optionally polls the busy flag until it clears or a poll limit is reached, then returns completion status.

Parameters:
- G_TAS_CYC, 4, clk cycles from rs/rw/data valid to en rise (≥40 ns at 100 MHz).
- G_PWEH_CYC, 24, clk cycles en held high (≥230 ns).
- G_TAH_CYC, 2, clk cycles rs/rw/data held after en fall (≥10 ns).
- G_TCYC_CYC, 50, minimum clk cycles between consecutive en rising edges (≥500 ns).
- G_POLL_MAX, 1000, maximum busy-flag reads before timeout (16-bit counter).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  request strobe
- o_req_ready  out  1  high when idle and able to accept a request
- i_req_rs  in  1  0 = instruction, 1 = data
- i_req_rw  in  1  0 = write, 1 = read
- i_req_data  in  8  byte to write
- i_poll_en  in  1  1 = poll busy flag after a write
- o_done  out  1  one-cycle completion pulse
- o_timeout  out  1  valid with o_done; poll limit hit
- o_rdata  out  8  byte read (read requests only); held until the next read
- o_poll_cnt  out  16  busy reads performed for the last request; held
- o_rs  out  1  LCD register select
- o_rw  out  1  LCD read/write
- o_en  out  1  LCD enable
- io_data  inout  8  LCD data bus

Behaviour:
- Reset (async assert, sync release): all outputs 0 except o_req_ready=1; io_data=Z; FSM=IDLE; all counters 0.
- io_data is driven with the latched byte only while o_rw=0. When o_rw=1 it is Z.
- Handshake: a request is accepted when i_req_valid && o_req_ready. Request fields are latched on acceptance. o_req_ready drops the following cycle and stays low until the cycle after o_done.
- FSM:
  - IDLE: on accept, set o_rs/o_rw/data and go to SETUP.
  - SETUP: hold G_TAS_CYC cycles, then set o_en=1 and go to ENH.
  - ENH: hold G_PWEH_CYC cycles. For a read, sample io_data into the read register on the last ENH cycle. Then clear o_en and go to HOLD.
  - HOLD: keep rs/rw/data for G_TAH_CYC cycles, then go to GAP.
  - GAP: wait until the cycle counter (reset at each en rise) reaches G_TCYC_CYC, then decide:
    - original request was a write with i_poll_en=1 → set o_rs=0, o_rw=1 and go to SETUP as a poll cycle.
    - poll cycle with sampled bit7=1 and poll count < G_POLL_MAX → repeat the poll.
    - otherwise → DONE.
  - DONE: pulse o_done for 1 cycle, update o_poll_cnt and o_timeout, return o_rs/o_rw to 0, go to IDLE.
- Poll count increments on each poll en fall. Timeout=1 only when the count equals G_POLL_MAX and the last sampled BF=1.
- Read requests and writes with i_poll_en=0 complete with o_poll_cnt=0 and o_timeout=0. o_rdata updates only for read requests, never on polls.
- en pulses always satisfy tAS/PWEH/tAH/tcycE for the parameterised counts. Back-to-back requests are spaced by the GAP wait.
- i_req_valid while not ready is ignored; the request must be held by the requester.
- Reset mid-transaction: o_en falls immediately (async), bus returns to Z, no o_done.
- Parameter values of 0 are treated as 1.

Test Plan:
- Write rs=1, data=0x41, i_poll_en=0 → one en pulse of 24 cycles, rs-to-en 4 cycles, data 0x41 held 2 cycles after en fall, o_done with o_poll_cnt=0; emulator logs WR_DATA.
- Write rs=0, data=0x80 then rs=1, data=0x48 → en rising edges ≥50 cycles apart; emulator DDRAM[0][0]=0x48.
- Write 0x01 with polling; bench returns BF=1 for 3 polls, then 0 → 4 poll en pulses with rs=0/rw=1; o_poll_cnt=4, o_timeout=0.
- G_POLL_MAX=8, BF stuck at 1 → exactly 8 polls; o_done with o_timeout=1, o_poll_cnt=8.
- Read rs=1 with bench driving 0x5A → o_rdata=0x5A at o_done; io_data never driven by the DUT while rw=1.
- Assert rst_n during ENH → o_en=0 in the same timestep, o_req_ready=1 after release, no o_done; a following write completes normally.
